hazard_forward_unit: RTL and testbench

- Pipeline control companion to the EX stage; produces the forwardA/forwardB selects that EX's operand muxes consume, and the load-use stall and branch-flush controls for IF/ID/EX.
- Keeps its own shadow copy of the destination/control fields of the instructions in EX, MEM and WB, advanced every clock. The datapath pipeline registers are not needed to drive it.
- Also keeps saturating stall and flush event counters for performance debug.

---
 rtl/hazard_forward_unit.sv | 114 +++++++++++
 tb/tb_hazard_forward_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// Forwarding-select, load-use stall and branch-flush control for a 5-stage pipeline.
// Tracks shadow EX/MEM/WB destination fields and saturating stall/flush event counters.
module hazard_forward_unit #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       RS1_ID,
   input  logic [4:0]       RS2_ID,
   input  logic [4:0]       RD_ID,
   input  logic             Uses_RS1_ID,
   input  logic             Uses_RS2_ID,
   input  logic             RegWrite_ID,
   input  logic             MemRead_ID,
   input  logic             Branch_Taken_EX,
   output logic [1:0]       forwardA,
   output logic [1:0]       forwardB,
   output logic             Stall,
   output logic             Flush,
   output logic [CNT_W-1:0] Stall_Count,
   output logic [CNT_W-1:0] Flush_Count
);

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       reg_write;
      logic       mem_read;
   } ex_slot_t;

   typedef struct packed {
      logic [4:0] rd;
      logic       reg_write;
   } wr_slot_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   ex_slot_t         ex_q, ex_d;
   wr_slot_t         mem_q, mem_d;
   wr_slot_t         wb_q, wb_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             load_use;

   // MEM is the youngest producer, so it is tested first; x0 never forwards.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input wr_slot_t  mem,
                                          input wr_slot_t  wb);
      logic [1:0] sel;
      sel = FWD_RF;
      if (mem.reg_write && (mem.rd != 5'd0) && (mem.rd == rs))
         sel = FWD_MEM;
      else if (wb.reg_write && (wb.rd != 5'd0) && (wb.rd == rs))
         sel = FWD_WB;
      return sel;
   endfunction

   // NOTE: every signal assigned in this block gets a default first, so no latch is inferred.
   always_comb begin
      forwardA = fwd_sel(ex_q.rs1, mem_q, wb_q);
      forwardB = fwd_sel(ex_q.rs2, mem_q, wb_q);

      load_use = ex_q.mem_read && (ex_q.rd != 5'd0) &&
                 ((Uses_RS1_ID && (ex_q.rd == RS1_ID)) ||
                  (Uses_RS2_ID && (ex_q.rd == RS2_ID)));
      Flush = Branch_Taken_EX;
      Stall = load_use && !Branch_Taken_EX;

      mem_d.rd        = ex_q.rd;
      mem_d.reg_write = ex_q.reg_write;
      wb_d            = mem_q;

      ex_d = '0;
      if (!Stall && !Flush) begin
         ex_d.rs1       = RS1_ID;
         ex_d.rs2       = RS2_ID;
         ex_d.rd        = RD_ID;
         ex_d.reg_write = RegWrite_ID;
         ex_d.mem_read  = MemRead_ID;
      end

      stall_cnt_d = stall_cnt_q;
      if (Stall && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);

      flush_cnt_d = flush_cnt_q;
      if (Flush && (flush_cnt_q != '1))
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   // NOTE: state registers use non-blocking assignments so all slots advance together on the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign Stall_Count = stall_cnt_q;
   assign Flush_Count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed self-checking bench for hazard_forward_unit; narrow counters make saturation reachable.
module tb_hazard_forward_unit;

   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic [4:0]       rs1_id, rs2_id, rd_id;
   logic             uses_rs1, uses_rs2, reg_write, mem_read, br_taken;
   logic [1:0]       forward_a, forward_b;
   logic             stall, flush;
   logic [CNT_W-1:0] stall_count, flush_count;

   int n_checks = 0;
   int n_fail   = 0;

   hazard_forward_unit #(.CNT_W(CNT_W)) dut (
      .clk             (clk),
      .reset           (reset),
      .RS1_ID          (rs1_id),
      .RS2_ID          (rs2_id),
      .RD_ID           (rd_id),
      .Uses_RS1_ID     (uses_rs1),
      .Uses_RS2_ID     (uses_rs2),
      .RegWrite_ID     (reg_write),
      .MemRead_ID      (mem_read),
      .Branch_Taken_EX (br_taken),
      .forwardA        (forward_a),
      .forwardB        (forward_b),
      .Stall           (stall),
      .Flush           (flush),
      .Stall_Count     (stall_count),
      .Flush_Count     (flush_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one ID instruction for a cycle; outputs settle 1 ns later, well before the next edge.
   task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic u1, input logic u2, input logic rw, input logic mr,
                        input logic br);
      @(negedge clk);
      rs1_id = rs1; rs2_id = rs2; rd_id = rd;
      uses_rs1 = u1; uses_rs2 = u2; reg_write = rw; mem_read = mr; br_taken = br;
      #1;
   endtask

   task automatic nop();
      issue(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      rs1_id = '0; rs2_id = '0; rd_id = '0;
      uses_rs1 = 0; uses_rs2 = 0; reg_write = 0; mem_read = 0; br_taken = 0;
      #2;
      check("rst_fwdA", forward_a, 2'b00);
      check("rst_fwdB", forward_b, 2'b00);
      check("rst_stall", stall, 1'b0);
      check("rst_flush", flush, 1'b0);
      check("rst_scnt", stall_count, 3'd0);
      check("rst_fcnt", flush_count, 3'd0);
      @(negedge clk);
      reset = 1'b0;

      // add x5,x1,x2 ; sub x6,x5,x3
      issue(5'd1, 5'd2, 5'd5, 1, 1, 1, 0, 0);
      issue(5'd5, 5'd3, 5'd6, 1, 1, 1, 0, 0);
      check("add_ex_fwdA", forward_a, 2'b00);
      nop();
      check("sub_fwdA_mem", forward_a, 2'b10);
      check("sub_fwdB_rf", forward_b, 2'b00);
      check("sub_stall", stall, 1'b0);
      nop();
      nop();

      // add x5,x1,x2 ; nop ; or x7,x4,x5
      issue(5'd1, 5'd2, 5'd5, 1, 1, 1, 0, 0);
      nop();
      issue(5'd4, 5'd5, 5'd7, 1, 1, 1, 0, 0);
      nop();
      check("or_fwdA_rf", forward_a, 2'b00);
      check("or_fwdB_wb", forward_b, 2'b01);
      nop();
      nop();

      // add x5,x1,x2 ; add x5,x5,x3 ; or x7,x4,x5  (x5 live in both MEM and WB)
      issue(5'd1, 5'd2, 5'd5, 1, 1, 1, 0, 0);
      issue(5'd5, 5'd3, 5'd5, 1, 1, 1, 0, 0);
      issue(5'd4, 5'd5, 5'd7, 1, 1, 1, 0, 0);
      check("add2_fwdA_mem", forward_a, 2'b10);
      nop();
      check("prio_fwdB_mem", forward_b, 2'b10);
      check("prio_fwdA_rf", forward_a, 2'b00);
      nop();
      nop();

      // lw x8,0(x1) ; add x9,x8,x8
      issue(5'd1, 5'd0, 5'd8, 1, 0, 1, 1, 0);
      issue(5'd8, 5'd8, 5'd9, 1, 1, 1, 0, 0);
      check("lu_stall", stall, 1'b1);
      check("lu_flush", flush, 1'b0);
      issue(5'd8, 5'd8, 5'd9, 1, 1, 1, 0, 0);
      check("lu_stall_one", stall, 1'b0);
      check("lu_scnt", stall_count, 3'd1);
      check("bubble_fwdA", forward_a, 2'b00);
      nop();
      check("lu_fwdA_wb", forward_a, 2'b01);
      check("lu_fwdB_wb", forward_b, 2'b01);
      check("lu_scnt_hold", stall_count, 3'd1);
      nop();
      nop();

      // lw x0 ; add x1,x0,x0 ; add x0,x1,x2 ; add x3,x0,x0
      issue(5'd1, 5'd0, 5'd0, 1, 0, 1, 1, 0);
      issue(5'd0, 5'd0, 5'd1, 1, 1, 1, 0, 0);
      check("lwx0_stall", stall, 1'b0);
      issue(5'd1, 5'd2, 5'd0, 1, 1, 1, 0, 0);
      check("x0_fwdA", forward_a, 2'b00);
      check("x0_fwdB", forward_b, 2'b00);
      issue(5'd0, 5'd0, 5'd3, 1, 1, 1, 0, 0);
      nop();
      check("addx0_fwdA", forward_a, 2'b00);
      check("addx0_fwdB", forward_b, 2'b00);
      nop();
      nop();

      // Taken branch while a load-use hazard sits in ID
      issue(5'd1, 5'd0, 5'd8, 1, 0, 1, 1, 0);
      issue(5'd8, 5'd8, 5'd9, 1, 1, 1, 0, 1);
      check("br_flush", flush, 1'b1);
      check("br_stall", stall, 1'b0);
      issue(5'd9, 5'd0, 5'd10, 1, 0, 1, 0, 0);
      check("br_fcnt", flush_count, 3'd1);
      check("br_scnt", stall_count, 3'd1);
      check("br_flush_off", flush, 1'b0);
      nop();
      check("br_bubble_fwdA", forward_a, 2'b00);
      nop();
      nop();

      // Reset asserted in the middle of a stall
      issue(5'd1, 5'd0, 5'd8, 1, 0, 1, 1, 0);
      issue(5'd8, 5'd8, 5'd9, 1, 1, 1, 0, 0);
      check("pre_rst_stall", stall, 1'b1);
      #1 reset = 1'b1;
      #1;
      check("mid_rst_stall", stall, 1'b0);
      check("mid_rst_scnt", stall_count, 3'd0);
      check("mid_rst_fcnt", flush_count, 3'd0);
      check("mid_rst_fwdA", forward_a, 2'b00);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("post_rst_stall", stall, 1'b0);
      nop();
      check("post_rst_fwdA", forward_a, 2'b00);
      check("post_rst_fwdB", forward_b, 2'b00);

      // Nine load-use stalls into a 3-bit counter: must pin at 7
      for (int i = 0; i < 9; i++) begin
         issue(5'd1, 5'd0, 5'd8, 1, 0, 1, 1, 0);
         issue(5'd8, 5'd8, 5'd9, 1, 1, 1, 0, 0);
         issue(5'd8, 5'd8, 5'd9, 1, 1, 1, 0, 0);
      end
      check("sat_scnt", stall_count, 3'd7);

      // Nine flush cycles into a 3-bit counter: must pin at 7
      for (int i = 0; i < 9; i++)
         issue(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
      nop();
      check("sat_fcnt", flush_count, 3'd7);
      check("sat_scnt_hold", stall_count, 3'd7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
